uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_receiver.sv | 137 +++++++++++++
 tb/tb_uart_receiver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, data width and default bit timing.
// The transmitter imports the same package.
package uart_pkg;

   localparam int DATA_WIDTH           = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 87;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous line that idles high.
// Both flops reset to 1, so a reset never looks like a start bit.
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
      end else begin
         meta_reg <= async_in;
         sync_reg <= meta_reg;
      end
   end

   assign sync_out = sync_reg;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: it checks the start bit at its mid-point, then samples each data bit
// and the stop bit one bit period apart. A low stop bit reports a framing error.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rx,
   output logic                  o_rx_dv,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_frame_err,
   output logic                  o_rx_busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic rx_s;

   uart_sync2 u_sync (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .async_in (i_rx),
      .sync_out (rx_s)
   );

   rx_state_t             state_reg, state_next;
   logic [CW-1:0]         cnt_reg,   cnt_next;
   logic [2:0]            bit_reg,   bit_next;
   logic [DATA_WIDTH-1:0] shift_reg, shift_next;
   logic [DATA_WIDTH-1:0] data_reg,  data_next;
   logic                  dv_reg,    dv_next;
   logic                  ferr_reg,  ferr_next;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         dv_reg    <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         data_reg  <= data_next;
         dv_reg    <= dv_next;
         ferr_reg  <= ferr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      dv_next    = 1'b0;
      ferr_next  = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!rx_s) begin
               state_next = ST_START;
               cnt_next   = '0;
            end
         end

         ST_START: begin
            if (cnt_reg == HALF_CNT) begin
               cnt_next = '0;
               if (!rx_s) begin
                  state_next = ST_DATA;
                  bit_next   = '0;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_reg == LAST_CNT) begin
               cnt_next   = '0;
               shift_next = {rx_s, shift_reg[DATA_WIDTH-1:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) begin
                  state_next = ST_STOP;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_STOP: begin
            if (cnt_reg == LAST_CNT) begin
               cnt_next = '0;
               if (rx_s) begin
                  data_next  = shift_reg;
                  dv_next    = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = ST_BREAK;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         // A held-low line must go high again before the next start bit can be found.
         ST_BREAK: begin
            if (rx_s) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign o_rx_dv        = dv_reg;
   assign o_rx_data      = data_reg;
   assign o_rx_frame_err = ferr_reg;
   assign o_rx_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: it queues the expected bytes and framing errors as each frame is sent,
// and monitors pop and compare them when o_rx_dv or o_rx_frame_err pulses.
`timescale 1ns/1ps
module tb_uart_receiver;
   import uart_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx16  = 1'b1;
   logic       rx87  = 1'b1;
   logic       dv16, ferr16, busy16;
   logic [7:0] data16;
   logic       dv87, ferr87, busy87;
   logic [7:0] data87;

   uart_receiver #(.CLKS_PER_BIT(16)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rx           (rx16),
      .o_rx_dv        (dv16),
      .o_rx_data      (data16),
      .o_rx_frame_err (ferr16),
      .o_rx_busy      (busy16)
   );

   uart_receiver #(.CLKS_PER_BIT(87)) dut87 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rx           (rx87),
      .o_rx_dv        (dv87),
      .o_rx_data      (data87),
      .o_rx_frame_err (ferr87),
      .o_rx_busy      (busy87)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } exp_t;

   exp_t q16[$];
   exp_t q87[$];
   exp_t e16, e87;
   int   dv16_cnt = 0, ferr16_cnt = 0, dv87_cnt = 0, ferr87_cnt = 0;
   int   last_dv_cyc = 0, prev_dv_cyc = 0;
   int   fall_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
      tests++;
      assert (obs >= lo && obs <= hi) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit line87, input logic v);
      if (line87) rx87 = v;
      else        rx16 = v;
   endtask

   // Start bit, 8 data bits LSB first, then the stop bit; each bit lasts `period` cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period, input bit line87);
      logic v;
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      v = 1'b0;
         else if (i == 9) v = stop_bit;
         else             v = b[i-1];
         if (i == 0) fall_cyc = cyc;
         drive(line87, v);
         wait_cyc(period);
      end
   endtask

   always @(negedge clk) begin
      if (dv16 || ferr16) begin
         chk("dv_ferr_exclusive16", {31'b0, dv16 & ferr16}, 32'd0);
         if (q16.size() == 0) begin
            chk("unexpected_pulse16", q16.size(), 32'd1);
         end else begin
            e16 = q16.pop_front();
            $display("[TB] rx16 event err=%0b data=%02h (expected err=%0b data=%02h)", ferr16, data16, e16.is_err, e16.data);
            chk("kind16", {31'b0, ferr16}, {31'b0, e16.is_err});
            chk("data16", {24'b0, data16}, {24'b0, e16.data});
         end
         if (dv16) begin
            dv16_cnt++;
            prev_dv_cyc = last_dv_cyc;
            last_dv_cyc = cyc;
         end
         if (ferr16) ferr16_cnt++;
      end
      if (dv87 || ferr87) begin
         chk("dv_ferr_exclusive87", {31'b0, dv87 & ferr87}, 32'd0);
         if (q87.size() == 0) begin
            chk("unexpected_pulse87", q87.size(), 32'd1);
         end else begin
            e87 = q87.pop_front();
            $display("[TB] rx87 event err=%0b data=%02h (expected err=%0b data=%02h)", ferr87, data87, e87.is_err, e87.data);
            chk("kind87", {31'b0, ferr87}, {31'b0, e87.is_err});
            chk("data87", {24'b0, data87}, {24'b0, e87.data});
         end
         if (dv87) dv87_cnt++;
         if (ferr87) ferr87_cnt++;
      end
   end

   initial begin
      int busy_n;

      // Reset state
      wait_cyc(3);
      chk("rst_dv",    {31'b0, dv16},   32'd0);
      chk("rst_ferr",  {31'b0, ferr16}, 32'd0);
      chk("rst_busy",  {31'b0, busy16}, 32'd0);
      chk("rst_data",  {24'b0, data16}, 32'd0);
      chk("rst_data87", {24'b0, data87}, 32'd0);
      rst_n = 1'b1;
      wait_cyc(20);

      // Short glitch: a 4-cycle low pulse is rejected at the start-bit mid-point
      rx16 = 1'b0;
      wait_cyc(4);
      rx16 = 1'b1;
      busy_n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy16) busy_n++;
      end
      wait_cyc(1);
      $display("[TB] glitch busy cycles=%0d", busy_n);
      chk_range("glitch_busy_cycles", busy_n, 1, 11);
      chk("glitch_no_dv",   dv16_cnt,   32'd0);
      chk("glitch_no_ferr", ferr16_cnt, 32'd0);
      chk("glitch_idle",    {31'b0, busy16}, 32'd0);

      // Framing error on 0x3C with the line held low, then a valid 0x5A
      q16.push_back('{is_err: 1'b1, data: 8'h00});
      send_frame(8'h3C, 1'b0, 16, 1'b0);
      wait_cyc(40);
      chk("ferr_count",     ferr16_cnt, 32'd1);
      chk("ferr_data_held", {24'b0, data16}, 32'h00);
      chk("break_busy",     {31'b0, busy16}, 32'd1);
      rx16 = 1'b1;
      wait_cyc(48);
      chk("break_exit_idle", {31'b0, busy16}, 32'd0);
      q16.push_back('{is_err: 1'b0, data: 8'h5A});
      send_frame(8'h5A, 1'b1, 16, 1'b0);
      wait_cyc(16);
      chk("after_break_dv",   dv16_cnt, 32'd1);
      chk("after_break_data", {24'b0, data16}, 32'h5A);

      // 0xA5 latency from the start-bit falling edge
      q16.push_back('{is_err: 1'b0, data: 8'hA5});
      send_frame(8'hA5, 1'b1, 16, 1'b0);
      wait_cyc(16);
      $display("[TB] A5 latency=%0d", last_dv_cyc - fall_cyc);
      chk_range("a5_latency", last_dv_cyc - fall_cyc, 153, 155);
      chk("a5_dv_count", dv16_cnt, 32'd2);
      chk("a5_data", {24'b0, data16}, 32'hA5);

      // Back-to-back 0x00 then 0xFF with no idle gap
      q16.push_back('{is_err: 1'b0, data: 8'h00});
      q16.push_back('{is_err: 1'b0, data: 8'hFF});
      send_frame(8'h00, 1'b1, 16, 1'b0);
      send_frame(8'hFF, 1'b1, 16, 1'b0);
      wait_cyc(16);
      $display("[TB] back-to-back spacing=%0d", last_dv_cyc - prev_dv_cyc);
      chk_range("b2b_spacing", last_dv_cyc - prev_dv_cyc, 159, 161);
      chk("b2b_dv_count", dv16_cnt, 32'd4);
      chk("b2b_data", {24'b0, data16}, 32'hFF);

      // Reset pulse during bit 4 of 0x81 aborts the frame; then a full 0x7E
      rx16 = 1'b0;
      wait_cyc(16);
      for (int i = 0; i < 4; i++) begin
         rx16 = (i == 0) ? 1'b1 : 1'b0;
         wait_cyc(16);
      end
      rx16 = 1'b0;
      wait_cyc(8);
      rst_n = 1'b0;
      wait_cyc(1);
      chk("midrst_data", {24'b0, data16}, 32'h00);
      chk("midrst_busy", {31'b0, busy16}, 32'd0);
      chk("midrst_dv",   {31'b0, dv16},   32'd0);
      chk("midrst_ferr", {31'b0, ferr16}, 32'd0);
      rst_n = 1'b1;
      rx16  = 1'b1;
      wait_cyc(48);
      chk("midrst_no_pulse", dv16_cnt + ferr16_cnt, 32'd5);
      q16.push_back('{is_err: 1'b0, data: 8'h7E});
      send_frame(8'h7E, 1'b1, 16, 1'b0);
      wait_cyc(16);
      chk("post_rst_dv",   dv16_cnt, 32'd5);
      chk("post_rst_data", {24'b0, data16}, 32'h7E);

      // CLKS_PER_BIT=87 receiver with the transmitter bit period 3% slow, then 3% fast
      q87.push_back('{is_err: 1'b0, data: 8'hC3});
      send_frame(8'hC3, 1'b1, 90, 1'b1);
      wait_cyc(174);
      q87.push_back('{is_err: 1'b0, data: 8'hC3});
      send_frame(8'hC3, 1'b1, 84, 1'b1);
      wait_cyc(174);
      chk("skew_dv_count",   dv87_cnt,   32'd2);
      chk("skew_ferr_count", ferr87_cnt, 32'd0);
      chk("skew_data",       {24'b0, data87}, 32'hC3);

      chk("q16_drained", q16.size(), 32'd0);
      chk("q87_drained", q87.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
